mem_d_axi_master: RTL and testbench

AXI4 master bridge for the CPU data port. Tagged requests on the `mem_d_*` interface become single-beat AXI4 read and write transactions. It sits between the core's data-side port and the AXI fabric, and is the initiator counterpart of the TCM's AXI slave port: it lets the core reach memory outside the TCM (for example, a second TCM's `axi_*` port). It holds one request outstanding at a time and returns read data, tag and error on a registered ack.

---
 rtl/biriscv_axi_pkg.sv | 29 ++
 rtl/mem_d_axi_master.sv | 201 ++++++++++++++++++++
 tb/tb_mem_d_axi_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_axi_pkg.sv
// Shared definitions for the biriscv AXI bridges.
//   - FSM state encoding for the data-port AXI master
//   - AXI burst/response constants
//   - Tag and ID widths used on the mem_d_* and axi_* interfaces
//   - resp_is_err(): true for SLVERR/DECERR responses
package biriscv_axi_pkg;

    localparam int unsigned TAG_W = 11;
    localparam int unsigned ID_W  = 4;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Bit 1 set covers both SLVERR (2'b10) and DECERR (2'b11).
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp & AXI_RESP_SLVERR) != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_d_axi_master.sv
// AXI4 master bridge for the CPU data port.
// Converts one tagged mem_d_* request at a time into a single-beat AXI4 read or write
// and returns read data, tag and error on a one-cycle ack.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mem_d_*_i              request: address, write data, rd, byte enables, tag, maintenance
//   mem_d_accept_o         high in IDLE only
//   mem_d_ack_o            one-cycle completion pulse with resp_tag/data_rd/error
//   axi_aw*/w*/b*          write address, data and response channels
//   axi_ar*/r*             read address and data channels
module mem_d_axi_master
    import biriscv_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o,
    output logic [31:0]      mem_d_data_rd_o,
    output logic             mem_d_error_o,

    output logic             axi_awvalid_o,
    output logic [31:0]      axi_awaddr_o,
    output logic [ID_W-1:0]  axi_awid_o,
    output logic [7:0]       axi_awlen_o,
    output logic [1:0]       axi_awburst_o,
    input  logic             axi_awready_i,

    output logic             axi_wvalid_o,
    output logic [31:0]      axi_wdata_o,
    output logic [3:0]       axi_wstrb_o,
    output logic             axi_wlast_o,
    input  logic             axi_wready_i,

    output logic             axi_bready_o,
    input  logic             axi_bvalid_i,
    input  logic [1:0]       axi_bresp_i,
    input  logic [ID_W-1:0]  axi_bid_i,

    output logic             axi_arvalid_o,
    output logic [31:0]      axi_araddr_o,
    output logic [ID_W-1:0]  axi_arid_o,
    output logic [7:0]       axi_arlen_o,
    output logic [1:0]       axi_arburst_o,
    input  logic             axi_arready_i,

    output logic             axi_rready_o,
    input  logic             axi_rvalid_i,
    input  logic [31:0]      axi_rdata_i,
    input  logic [1:0]       axi_rresp_i,
    input  logic [ID_W-1:0]  axi_rid_i,
    input  logic             axi_rlast_i
);

    state_e           r_state;
    logic             r_awvalid;
    logic             r_wvalid;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_strb;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_rdata;
    logic             r_error;

    state_e           w_state_d;
    logic             w_awvalid_d;
    logic             w_wvalid_d;
    logic             w_error_d;
    logic             w_latch;
    logic             w_capture;
    logic             w_accept;
    logic             w_req;

    assign w_accept = (r_state == ST_IDLE);
    assign w_req    = w_accept & ((|mem_d_wr_i) | mem_d_rd_i | mem_d_flush_i |
                                  mem_d_invalidate_i | mem_d_writeback_i);

    always_comb begin
        w_state_d   = r_state;
        w_awvalid_d = r_awvalid;
        w_wvalid_d  = r_wvalid;
        w_error_d   = r_error;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    // Write beats read beats maintenance; losers are dropped silently.
                    if (|mem_d_wr_i) begin
                        w_state_d   = ST_WRITE;
                        w_awvalid_d = 1'b1;
                        w_wvalid_d  = 1'b1;
                    end else if (mem_d_rd_i) begin
                        w_state_d = ST_READ;
                    end else begin
                        w_state_d = ST_DONE;
                        w_error_d = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, in either order.
                if (r_awvalid && axi_awready_i) w_awvalid_d = 1'b0;
                if (r_wvalid && axi_wready_i)   w_wvalid_d  = 1'b0;
                if (!w_awvalid_d && !w_wvalid_d) w_state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (axi_bvalid_i) begin
                    w_state_d = ST_DONE;
                    w_error_d = resp_is_err(axi_bresp_i);
                end
            end
            ST_READ: begin
                if (axi_arready_i) w_state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (axi_rvalid_i) begin
                    w_state_d = ST_DONE;
                    w_error_d = resp_is_err(axi_rresp_i);
                    w_capture = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_tag     <= '0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_awvalid <= w_awvalid_d;
            r_wvalid  <= w_wvalid_d;
            r_error   <= w_error_d;
            if (w_latch) begin
                r_addr  <= {mem_d_addr_i[31:2], 2'b00};
                r_wdata <= mem_d_data_wr_i;
                r_strb  <= mem_d_wr_i;
                r_tag   <= mem_d_req_tag_i;
            end
            if (w_capture) r_rdata <= axi_rdata_i;
        end
    end

    assign mem_d_accept_o   = w_accept;
    assign mem_d_ack_o      = (r_state == ST_DONE);
    assign mem_d_resp_tag_o = r_tag;
    assign mem_d_data_rd_o  = r_rdata;
    assign mem_d_error_o    = r_error;

    assign axi_awvalid_o = r_awvalid;
    assign axi_awaddr_o  = r_addr;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = 8'd0;
    assign axi_awburst_o = AXI_BURST_INCR;

    assign axi_wvalid_o  = r_wvalid;
    assign axi_wdata_o   = r_wdata;
    assign axi_wstrb_o   = r_strb;
    assign axi_wlast_o   = 1'b1;

    assign axi_bready_o  = (r_state == ST_WAIT_B);

    assign axi_arvalid_o = (r_state == ST_READ);
    assign axi_araddr_o  = r_addr;
    assign axi_arid_o    = AXI_ID;
    assign axi_arlen_o   = 8'd0;
    assign axi_arburst_o = AXI_BURST_INCR;

    assign axi_rready_o  = (r_state == ST_WAIT_R);

    logic w_unused;
    assign w_unused = ^{mem_d_cacheable_i, mem_d_addr_i[1:0], axi_bid_i, axi_rid_i, axi_rlast_i};

endmodule

// File: tb/tb_mem_d_axi_master.sv
module tb_mem_d_axi_master;
    import biriscv_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic [31:0] mem_d_addr, mem_d_data_wr, mem_d_data_rd;
    logic        mem_d_rd, mem_d_cacheable, mem_d_invalidate, mem_d_writeback, mem_d_flush;
    logic [3:0]  mem_d_wr;
    logic [10:0] mem_d_req_tag, mem_d_resp_tag;
    logic        mem_d_accept, mem_d_ack, mem_d_error;

    logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
    logic        arvalid, arready, rready, rvalid, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;

    mem_d_axi_master #(.AXI_ID(4'd0)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mem_d_addr_i(mem_d_addr), .mem_d_data_wr_i(mem_d_data_wr), .mem_d_rd_i(mem_d_rd),
        .mem_d_wr_i(mem_d_wr), .mem_d_cacheable_i(mem_d_cacheable),
        .mem_d_req_tag_i(mem_d_req_tag), .mem_d_invalidate_i(mem_d_invalidate),
        .mem_d_writeback_i(mem_d_writeback), .mem_d_flush_i(mem_d_flush),
        .mem_d_accept_o(mem_d_accept), .mem_d_ack_o(mem_d_ack),
        .mem_d_resp_tag_o(mem_d_resp_tag), .mem_d_data_rd_o(mem_d_data_rd),
        .mem_d_error_o(mem_d_error),
        .axi_awvalid_o(awvalid), .axi_awaddr_o(awaddr), .axi_awid_o(awid), .axi_awlen_o(awlen),
        .axi_awburst_o(awburst), .axi_awready_i(awready),
        .axi_wvalid_o(wvalid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wready_i(wready),
        .axi_bready_o(bready), .axi_bvalid_i(bvalid), .axi_bresp_i(bresp), .axi_bid_i(bid),
        .axi_arvalid_o(arvalid), .axi_araddr_o(araddr), .axi_arid_o(arid), .axi_arlen_o(arlen),
        .axi_arburst_o(arburst), .axi_arready_i(arready),
        .axi_rready_o(rready), .axi_rvalid_i(rvalid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
        .axi_rid_i(rid), .axi_rlast_i(rlast)
    );

    int checks = 0;
    int failures = 0;

    // Slave behaviour for the next transaction: wait cycles per channel and responses.
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    // Reference model state: last read data returned by the bridge.
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'h0; bid = 4'(($urandom));
        rid = 4'($urandom); rlast = 1'($urandom);
    endtask

    task automatic clear_req();
        mem_d_rd = 1'b0; mem_d_wr = 4'h0; mem_d_flush = 1'b0; mem_d_invalidate = 1'b0;
        mem_d_writeback = 1'b0; mem_d_cacheable = 1'($urandom);
    endtask

    // Must be called at a negedge. Presents the request this cycle, acts as AXI slave until
    // the ack, then advances one more cycle and checks the return to IDLE.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic rd, input logic [3:0] wr, input logic fl,
                           input logic inv, input logic wb, input logic [10:0] tag,
                           input bit hold);
        int kind, exp_lat, exp_err, lat, cyc;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_hs, w_hs, ar_hs;
        bit b_pend, b_done, r_pend, r_done, got_ack, acc_viol, wd_viol, stray, aw_seen, w_seen;
        logic [31:0] exp_data, o_awaddr, o_wdata, o_araddr, ack_data;
        logic [31:0] o_awfix, o_arfix;
        logic [10:0] ack_tag;
        logic        ack_err;
        logic [3:0]  o_wstrb;

        kind = (wr != 4'h0) ? 0 : (rd ? 1 : 2);
        if (kind == 0) exp_lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
        else if (kind == 1) exp_lat = 3 + ar_wait + r_wait;
        else exp_lat = 1;
        exp_err  = (kind == 0) ? int'(cfg_bresp[1]) : (kind == 1) ? int'(cfg_rresp[1]) : 0;
        exp_data = (kind == 1) ? cfg_rdata : last_rdata;

        mem_d_addr = addr; mem_d_data_wr = data; mem_d_rd = rd; mem_d_wr = wr;
        mem_d_flush = fl; mem_d_invalidate = inv; mem_d_writeback = wb; mem_d_req_tag = tag;

        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_hs = -1; w_hs = -1; ar_hs = -1; lat = -1;
        b_pend = 0; b_done = 0; r_pend = 0; r_done = 0; got_ack = 0;
        acc_viol = 0; wd_viol = 0; stray = 0; aw_seen = 0; w_seen = 0;
        o_awaddr = '0; o_wdata = '0; o_araddr = '0; o_wstrb = '0; o_awfix = '0; o_arfix = '0;
        ack_data = '0; ack_tag = '0; ack_err = 1'b0;
        cyc = 0;

        while (cyc < 40) begin
            slave_idle();
            if (cyc == 0) chk({name, "_accept"}, 32'(mem_d_accept), 32'd1);
            else if (mem_d_accept) acc_viol = 1;
            if (mem_d_ack) begin
                got_ack = 1; lat = cyc;
                ack_data = mem_d_data_rd; ack_tag = mem_d_resp_tag; ack_err = mem_d_error;
                break;
            end
            if (kind != 0 && (awvalid || wvalid || bready)) stray = 1;
            if (kind != 1 && (arvalid || rready)) stray = 1;
            // Valid may not drop before its handshake nor stay up after it.
            if (aw_seen && aw_hs < 0 && !awvalid) wd_viol = 1;
            if (w_seen && w_hs < 0 && !wvalid) wd_viol = 1;
            if ((aw_hs >= 0 && awvalid) || (w_hs >= 0 && wvalid)) wd_viol = 1;
            if (ar_hs >= 0 && arvalid) wd_viol = 1;

            awready = awvalid && aw_hs < 0 && aw_cnt == aw_wait;
            wready  = wvalid && w_hs < 0 && w_cnt == w_wait;
            arready = arvalid && ar_hs < 0 && ar_cnt == ar_wait;
            bvalid  = b_pend && b_cnt == b_wait;
            bresp   = bvalid ? cfg_bresp : 2'b00;
            rvalid  = r_pend && r_cnt == r_wait;
            rresp   = rvalid ? cfg_rresp : 2'b00;
            rdata   = rvalid ? cfg_rdata : ~cfg_rdata;

            if (awvalid) begin
                aw_seen = 1;
                if (awready) begin
                    aw_hs = cyc; o_awaddr = awaddr;
                    o_awfix = {12'h0, awid, awlen, 6'h0, awburst};
                end else aw_cnt++;
            end
            if (wvalid) begin
                w_seen = 1;
                if (wready) begin
                    w_hs = cyc; o_wdata = wdata; o_wstrb = wstrb;
                    if (!wlast) wd_viol = 1;
                end else w_cnt++;
            end
            if (arvalid) begin
                if (arready) begin
                    ar_hs = cyc; o_araddr = araddr;
                    o_arfix = {12'h0, arid, arlen, 6'h0, arburst};
                end else ar_cnt++;
            end
            if (bvalid && bready) begin b_pend = 0; b_done = 1; end
            else if (b_pend && b_cnt < b_wait) b_cnt++;
            if (rvalid && rready) begin r_pend = 0; r_done = 1; end
            else if (r_pend && r_cnt < r_wait) r_cnt++;
            if (!b_pend && !b_done && aw_hs >= 0 && w_hs >= 0) b_pend = 1;
            if (!r_pend && !r_done && ar_hs >= 0) r_pend = 1;

            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) clear_req();
        end

        chk({name, "_ack_seen"}, 32'(got_ack), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_tag"}, 32'(ack_tag), 32'(tag));
        chk({name, "_data"}, ack_data, exp_data);
        chk({name, "_error"}, 32'(ack_err), 32'(exp_err));
        chk({name, "_accept_low"}, 32'(acc_viol), 32'd0);
        chk({name, "_valid_rules"}, 32'(wd_viol), 32'd0);
        chk({name, "_no_stray_axi"}, 32'(stray), 32'd0);
        if (kind == 0) begin
            chk({name, "_awaddr"}, o_awaddr, addr & 32'hFFFF_FFFC);
            chk({name, "_aw_fixed"}, o_awfix, 32'h0000_0001);
            chk({name, "_wdata"}, o_wdata, data);
            chk({name, "_wstrb"}, 32'(o_wstrb), 32'(wr));
            chk({name, "_aw_hs_cycle"}, 32'(aw_hs), 32'(1 + aw_wait));
            chk({name, "_w_hs_cycle"}, 32'(w_hs), 32'(1 + w_wait));
        end else if (kind == 1) begin
            chk({name, "_araddr"}, o_araddr, addr & 32'hFFFF_FFFC);
            chk({name, "_ar_fixed"}, o_arfix, 32'h0000_0001);
            chk({name, "_ar_hs_cycle"}, 32'(ar_hs), 32'(1 + ar_wait));
            last_rdata = cfg_rdata;
        end

        @(negedge clk);
        slave_idle();
        chk({name, "_ack_pulse"}, 32'(mem_d_ack), 32'd0);
        chk({name, "_accept_back"}, 32'(mem_d_accept), 32'd1);
        chk({name, "_data_hold"}, mem_d_data_rd, last_rdata);
    endtask

    task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_wait = aw; w_wait = w; ar_wait = ar; b_wait = b; r_wait = r;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_wait_r, ack_after_rst;
        int sel;
        logic [3:0] wr_r;
        logic m0, m1, m2;

        rst_ni = 1'b0;
        mem_d_addr = '0; mem_d_data_wr = '0; mem_d_req_tag = '0;
        clear_req();
        slave_idle();
        last_rdata = '0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'h0, awvalid, wvalid, arvalid, bready, rready, mem_d_ack}, 32'h0);
        chk("reset_accept", 32'(mem_d_accept), 32'd1);
        chk("reset_error", 32'(mem_d_error), 32'd0);
        chk("reset_data", mem_d_data_rd, 32'h0);
        chk("reset_tag", 32'(mem_d_resp_tag), 32'h0);
        chk("reset_addr", awaddr, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF);
        run_txn("read", 32'h0000_1004, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'h2A, 1'b0);

        set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn("write", 32'h0000_2002, 32'h1234_5678, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0,
                11'h155, 1'b0);

        set_slave(0, 2, 0, 1, 0, 2'b10, 2'b00, 32'h0);
        run_txn("wr_err", 32'h0000_3000, 32'hA5A5_0F0F, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0,
                11'h011, 1'b0);

        set_slave(0, 0, 1, 0, 2, 2'b00, 2'b11, 32'hCAFE_F00D);
        run_txn("rd_err", 32'h0000_4008, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'h022, 1'b0);

        run_txn("flush", 32'h0000_5000, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 11'h7FF, 1'b0);

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1111_2222);
        run_txn("prio", 32'h0000_6000, 32'h7777_8888, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0,
                11'h033, 1'b0);

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_CAFE);
        run_txn("b2b_first", 32'h0000_7000, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'h044, 1'b1);
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFEED_FACE);
        run_txn("b2b_second", 32'h0000_7000, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'h044, 1'b0);

        for (int i = 0; i < 24; i++) begin
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom),
                      2'($urandom), $urandom);
            sel = $urandom_range(0, 2);
            m0 = 1'($urandom); m1 = 1'($urandom); m2 = 1'($urandom);
            wr_r = 4'($urandom_range(1, 15));
            if (sel == 0) begin
                run_txn("rand_wr", $urandom, $urandom, 1'($urandom), wr_r, m0, m1, m2,
                        11'($urandom), 1'b0);
            end else if (sel == 1) begin
                run_txn("rand_rd", $urandom, $urandom, 1'b1, 4'h0, m0, m1, m2,
                        11'($urandom), 1'b0);
            end else begin
                if (!(m0 || m1 || m2)) m1 = 1'b1;
                run_txn("rand_maint", $urandom, $urandom, 1'b0, 4'h0, m0, m1, m2,
                        11'($urandom), 1'b0);
            end
        end

        // Reset while waiting for read data: nothing may complete afterwards.
        mem_d_addr = 32'h0000_8000; mem_d_req_tag = 11'h055; mem_d_rd = 1'b1;
        arready = 1'b1;
        seen_wait_r = 0;
        for (int c = 0; c < 10 && !seen_wait_r; c++) begin
            @(negedge clk);
            mem_d_rd = 1'b0;
            if (rready) seen_wait_r = 1;
        end
        chk("rst_reached_wait_r", 32'(seen_wait_r), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_outputs", {26'h0, awvalid, wvalid, arvalid, bready, rready, mem_d_ack},
            32'h0);
        chk("rst_mid_accept", 32'(mem_d_accept), 32'd1);
        arready = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        ack_after_rst = 0;
        for (int c = 0; c < 6; c++) begin
            rvalid = 1'b1; rdata = 32'h5555_AAAA;
            @(negedge clk);
            if (mem_d_ack) ack_after_rst = 1;
        end
        rvalid = 1'b0;
        chk("rst_no_ack", 32'(ack_after_rst), 32'd0);
        chk("rst_data_cleared", mem_d_data_rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
